// File: rtl/matrix_scan_reader.sv
// HUB75 64x32 1:16-scan panel driver with BCM, reading the 1024x48 frame memory.
// Define MATRIX_TEST_PATTERN_EN to add the test_pattern input.
module matrix_scan_reader #(
  parameter int BIT_DEPTH  = 8,
  parameter int BASE_TICKS = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [47:0] mem_out,
`ifdef MATRIX_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [9:0]  mem_address,
  output logic [47:0] mem_data,
  output logic        mem_write_enable,
  output logic        mem_clk,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        hub_clk,
  output logic        lat,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_done
);

  localparam int DW = $clog2(BASE_TICKS << (BIT_DEPTH - 1)) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_BLANK = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DISP  = 3'd4;

  localparam logic [7:0] LAT_CYC    = 8'(RD_LATENCY);
  localparam logic [2:0] LAST_PLANE = 3'(BIT_DEPTH - 1);
  localparam logic [2:0] BIT_OFS    = 3'(8 - BIT_DEPTH);

  logic [2:0]    state;
  logic [3:0]    row;
  logic [2:0]    plane;
  logic [5:0]    col;
  logic [7:0]    shift_cnt;
  logic [DW-1:0] disp_cnt;

  logic [7:0]    d;
  logic          in_win;
  logic          load;
  logic          rise;
  logic          shift_end;
  logic [2:0]    bsel;
  logic [47:0]   word;
  logic [DW-1:0] plane_len;
  logic          disp_end;
  logic          last_plane;
  logic [3:0]    nrow;

  // d counts shift cycles as seen by the returning read data
  assign d         = shift_cnt - LAT_CYC;
  assign in_win    = (shift_cnt >= LAT_CYC) && !d[7];
  assign load      = in_win && !d[0];
  assign rise      = in_win && d[0];
  assign shift_end = shift_cnt == (LAT_CYC + 8'd128);
  assign bsel      = BIT_OFS + plane;

`ifdef MATRIX_TEST_PATTERN_EN
  assign word = test_pattern
    ? {8'hFF, row, 4'h0, d[6:1], 2'b00,
       8'hFF, row, 4'h0, d[6:1], 2'b00}
    : mem_out;
`else
  assign word = mem_out;
`endif

  assign plane_len  = DW'(BASE_TICKS) << plane;
  assign disp_end   = disp_cnt == (plane_len - DW'(1));
  assign last_plane = plane == LAST_PLANE;
  assign nrow       = last_plane ? row + 4'd1 : row;

  assign oe_n       = state != S_DISP;
  assign lat        = state == S_LATCH;
  assign frame_done = (state == S_DISP) && disp_end
                    && last_plane && (row == 4'd15);

  assign mem_data         = '0;
  assign mem_write_enable = 1'b0;
  assign mem_clk          = clk;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      shift_cnt   <= '0;
      disp_cnt    <= '0;
      mem_address <= '0;
      row_addr    <= '0;
      hub_clk     <= 1'b0;
      {r1, g1, b1, r2, g2, b2} <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_SHIFT;
            shift_cnt   <= '0;
            col         <= '0;
            mem_address <= {row, 6'd0};
          end
        end
        S_SHIFT: begin
          shift_cnt <= shift_cnt + 8'd1;
          if (shift_cnt[0] && col != 6'd63) begin
            col         <= col + 6'd1;
            mem_address <= {row, col + 6'd1};
          end
          if (load) begin
            hub_clk <= 1'b0;
            r1 <= word[{3'd0, bsel}];
            g1 <= word[{3'd1, bsel}];
            b1 <= word[{3'd2, bsel}];
            r2 <= word[{3'd3, bsel}];
            g2 <= word[{3'd4, bsel}];
            b2 <= word[{3'd5, bsel}];
          end
          if (rise) hub_clk <= 1'b1;
          if (shift_end) begin
            hub_clk <= 1'b0;
            state   <= S_BLANK;
          end
        end
        S_BLANK: begin
          row_addr <= row;
          state    <= S_LATCH;
        end
        S_LATCH: begin
          disp_cnt <= '0;
          state    <= S_DISP;
        end
        S_DISP: begin
          disp_cnt <= disp_cnt + DW'(1);
          if (disp_end) begin
            plane <= last_plane ? 3'd0 : plane + 3'd1;
            row   <= nrow;
            if (enable) begin
              state       <= S_SHIFT;
              shift_cnt   <= '0;
              col         <= '0;
              mem_address <= {nrow, 6'd0};
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Directed bench for matrix_scan_reader: reset, shift data, BCM timing,
// protocol rules, pause/resume, reset mid-display and the test pattern.
module tb_matrix_scan_reader;

  localparam int BD  = 8;
  localparam int BT  = 1;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [47:0] mem_out;
  logic [9:0]  mem_address;
  logic [47:0] mem_data;
  logic        mem_write_enable;
  logic        mem_clk;
  logic        r1, g1, b1, r2, g2, b2;
  logic        hub_clk, lat, oe_n, frame_done;
  logic [3:0]  row_addr;
  logic        tp_on;
`ifdef MATRIX_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
  assign tp_on = test_pattern;
`else
  assign tp_on = 1'b0;
`endif

  always #5 clk = ~clk;

  matrix_scan_reader #(
    .BIT_DEPTH(BD), .BASE_TICKS(BT), .RD_LATENCY(LAT)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_out(mem_out),
`ifdef MATRIX_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_write_enable(mem_write_enable), .mem_clk(mem_clk),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .hub_clk(hub_clk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done)
  );

  function automatic logic [47:0] mk(input logic [9:0] a);
    return {a[7:0] ^ 8'hA5, a[9:2], ~a[7:0],
            a[7:0] + 8'h3C, a[9:2] ^ 8'h96, a[7:0]};
  endfunction

  // two-stage read pipeline: data appears two cycles after the address
  logic        zero_mem = 1'b0;
  logic [47:0] m1;
  always @(posedge clk) begin
    m1      <= zero_mem ? 48'd0 : mk(mem_address);
    mem_out <= m1;
  end

  int errors = 0;
  int checks = 0;

  int mrow = 0, mplane = 0, rise_cnt = 0, low_cnt = 0;
  int lat_cnt = 0, fd_cnt = 0, rise_total = 0;
  int last_col = -1, last_plane = -1;
  logic       prev_hub = 1'b0;
  logic [5:0] prev_rgb = '0;
  logic [3:0] prev_ra = '0;
  logic       rst_q = 1'b1;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    logic [47:0] w;
    logic [5:0]  got, exp;
    logic [5:0]  c6;
    int b;
    got = {b2, g2, r2, b1, g1, r1};
    if (rst_q) begin
      mrow = 0; mplane = 0; rise_cnt = 0; low_cnt = 0;
    end else begin
      if (hub_clk && !prev_hub) begin
        c6 = 6'(rise_cnt);
        if (tp_on)
          w = {8'hFF, mrow[3:0], 4'h0, c6, 2'b00,
               8'hFF, mrow[3:0], 4'h0, c6, 2'b00};
        else if (zero_mem)
          w = '0;
        else
          w = mk({mrow[3:0], c6});
        b = 8 - BD + mplane;
        exp = {w[40+b], w[32+b], w[24+b], w[16+b], w[8+b], w[b]};
        checks++;
        if (got !== exp || rise_cnt >= 64) begin
          errors++;
          $display("FAIL rise_data row=%0d plane=%0d col=%0d got=%b exp=%b",
                   mrow, mplane, rise_cnt, got, exp);
        end
        checks++;
        if (got !== prev_rgb) begin
          errors++;
          $display("FAIL rise_stable col=%0d got=%b before=%b",
                   rise_cnt, got, prev_rgb);
        end
        last_col = rise_cnt; last_plane = mplane;
        rise_cnt++; rise_total++;
      end
      if (lat) begin
        checks++;
        if (rise_cnt != 64 || row_addr !== mrow[3:0] || oe_n !== 1'b1) begin
          errors++;
          $display("FAIL latch rises=%0d exp=64 row_addr=%0d exp=%0d oe_n=%b",
                   rise_cnt, row_addr, mrow, oe_n);
        end
        lat_cnt++; rise_cnt = 0;
      end
      if (oe_n === 1'b0) begin
        checks++;
        if (lat !== 1'b0 || row_addr !== prev_ra) begin
          errors++;
          $display("FAIL protocol lat=%b row_addr=%0d prev=%0d while oe_n=0",
                   lat, row_addr, prev_ra);
        end
        low_cnt++;
        if (frame_done === 1'b1) begin
          fd_cnt++;
          checks++;
          if (mrow != 15 || mplane != BD - 1 || low_cnt != (BT << mplane)) begin
            errors++;
            $display("FAIL frame_done at row=%0d plane=%0d tick=%0d exp 15/%0d",
                     mrow, mplane, low_cnt, BD - 1);
          end
        end
      end else if (low_cnt > 0) begin
        checks++;
        if (low_cnt != (BT << mplane)) begin
          errors++;
          $display("FAIL display_len plane=%0d got=%0d exp=%0d",
                   mplane, low_cnt, BT << mplane);
        end
        low_cnt = 0;
        if (mplane == BD - 1) begin
          mplane = 0;
          mrow = (mrow + 1) % 16;
        end else begin
          mplane++;
        end
      end
      if (frame_done === 1'b1 && oe_n !== 1'b0) begin
        checks++; errors++;
        $display("FAIL frame_done_outside_display oe_n=%b", oe_n);
      end
      checks++;
      if (mem_write_enable !== 1'b0 || mem_data !== 48'd0) begin
        errors++;
        $display("FAIL no_write we=%b data=%h exp 0/0",
                 mem_write_enable, mem_data);
      end
    end
    prev_hub = hub_clk;
    prev_rgb = got;
    prev_ra  = row_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    lat_cnt = 0; fd_cnt = 0; rise_total = 0;
    enable = en;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    @(negedge clk); #1;
    checks++;
    if (oe_n !== 1'b1 || lat !== 1'b0 || hub_clk !== 1'b0 ||
        mem_address !== 10'd0 || row_addr !== 4'd0 || frame_done !== 1'b0 ||
        {r1, g1, b1, r2, g2, b2} !== 6'd0) begin
      errors++;
      $display("FAIL reset_values oe_n=%b lat=%b hub=%b addr=%0d ra=%0d rgb=%b",
               oe_n, lat, hub_clk, mem_address, row_addr,
               {r1, g1, b1, r2, g2, b2});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (oe_n !== 1'b1 || lat !== 1'b0 || hub_clk !== 1'b0 ||
          mem_address !== 10'd0 || row_addr !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_scan_data;
    int n;
    do_reset(1'b1);
    for (n = 0; n < 600 && lat_cnt < 1; n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (lat_cnt != 1 || rise_total != 64) begin
      errors++;
      $display("FAIL first_shift lat=%0d rises=%0d exp 1/64",
               lat_cnt, rise_total);
    end
  endtask

  task automatic test_full_frame;
    int n;
    for (n = 0; n < 25000 && fd_cnt < 1; n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (fd_cnt != 1 || lat_cnt != 128 || rise_total != 128 * 64) begin
      errors++;
      $display("FAIL frame1 fd=%0d lat=%0d rises=%0d exp 1/128/8192",
               fd_cnt, lat_cnt, rise_total);
    end
    tick(2);
    checks++;
    if (mrow != 0 || mplane != 0) begin
      errors++;
      $display("FAIL frame_wrap row=%0d plane=%0d exp 0/0", mrow, mplane);
    end
    for (n = 0; n < 25000 && fd_cnt < 2; n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (fd_cnt != 2 || lat_cnt != 256) begin
      errors++;
      $display("FAIL frame2 fd=%0d lat=%0d exp 2/256", fd_cnt, lat_cnt);
    end
  endtask

  task automatic test_enable_pause;
    int n, bad, r0;
    logic [47:0] w;
    do_reset(1'b1);
    for (n = 0; n < 12000 && !(mrow == 5 && mplane == 3 && rise_cnt == 10); n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (n >= 12000) begin
      errors++;
      $display("FAIL reach_row5_plane3 timeout row=%0d plane=%0d", mrow, mplane);
    end
    enable = 1'b0;
    for (n = 0; n < 400 && oe_n !== 1'b0; n++) begin
      @(negedge clk); #1;
    end
    for (n = 0; n < 400 && oe_n !== 1'b1; n++) begin
      @(negedge clk); #1;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (oe_n !== 1'b1 || hub_clk !== 1'b0 || lat !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || mrow != 5 || mplane != 4 || rise_cnt != 0) begin
      errors++;
      $display("FAIL pause bad=%0d row=%0d plane=%0d rises=%0d exp 0/5/4/0",
               bad, mrow, mplane, rise_cnt);
    end
    r0 = rise_total;
    enable = 1'b1;
    for (n = 0; n < 100 && rise_total == r0; n++) begin
      @(negedge clk); #1;
    end
    w = mk(10'd320);
    checks++;
    if (last_plane != 4 || last_col != 0 ||
        {b1, g1, r1} !== {w[20], w[12], w[4]}) begin
      errors++;
      $display("FAIL resume plane=%0d col=%0d rgb=%b exp 4/0/%b",
               last_plane, last_col, {b1, g1, r1}, {w[20], w[12], w[4]});
    end
    for (n = 0; n < 400 && !(oe_n === 1'b0 && mplane >= 2); n++) begin
      @(negedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (oe_n !== 1'b1 || lat !== 1'b0 || hub_clk !== 1'b0 ||
        row_addr !== 4'd0 || mem_address !== 10'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_display oe_n=%b lat=%b hub=%b ra=%0d addr=%0d",
               oe_n, lat, hub_clk, row_addr, mem_address);
    end
    lat_cnt = 0;
    reset = 1'b0;
    for (n = 0; n < 400 && lat_cnt < 1; n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (lat_cnt != 1 || last_plane != 0 || row_addr !== 4'd0) begin
      errors++;
      $display("FAIL restart lat=%0d plane=%0d ra=%0d exp 1/0/0",
               lat_cnt, last_plane, row_addr);
    end
  endtask

`ifdef MATRIX_TEST_PATTERN_EN
  task automatic test_pattern_mode;
    int n, r0;
    zero_mem = 1'b1;
    test_pattern = 1'b1;
    do_reset(1'b1);
    r0 = 0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (rise_total != r0 && last_col == 32 && last_plane == 7) break;
      r0 = rise_total;
    end
    checks++;
    if (n >= 3000 || {r1, r2, b1, b2, g1} !== 5'b11110) begin
      errors++;
      $display("FAIL pattern_col32_p7 r1r2b1b2g1=%b exp=11110 n=%0d",
               {r1, r2, b1, b2, g1}, n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_data();
    test_full_frame();
    test_enable_pause();
`ifdef MATRIX_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
